// File: rtl/gray_updown_counter_pkg.sv
// Shared definitions for the Gray-code up/down counter: default width, step
// encoding and a generic binary-to-Gray helper.
package gray_updown_counter_pkg;

  localparam int DefaultWidth = 3;
  localparam int MaxWidth     = 32;

  // What the counter does on the coming edge, after load/enable priority.
  typedef enum logic [1:0] {
    OpHold = 2'd0,
    OpLoad = 2'd1,
    OpInc  = 2'd2,
    OpDec  = 2'd3
  } stepOp_e;

  function automatic logic [MaxWidth-1:0] bin2Gray(input logic [MaxWidth-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/gray_updown_counter_bin_to_gray.sv
// Combinational binary-to-Gray converter: MSB passes through, every lower bit
// is the XOR of itself and its upper neighbour.
module bin_to_gray_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] binIn,
  output logic [WIDTH-1:0] grayOut
);

  assign grayOut[WIDTH-1] = binIn[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_xor
    assign grayOut[i] = binIn[i+1] ^ binIn[i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Binary up/down counter with a registered Gray image, terminal-count pulse
// and optional saturation; every output is a flop fed from next-state logic.
module gray_updown_counter
  import gray_updown_counter_pkg::*;
#(
  parameter int WIDTH    = DefaultWidth,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MaxCount  = '1;
  localparam logic [WIDTH-1:0] MinCount  = '0;
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ResetCnt  = '0;
  localparam logic [WIDTH-1:0] ResetGray = '0;

  stepOp_e          stepOp;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nextCnt;
  logic [WIDTH-1:0] nextGray;
  logic             nextWrap;
  logic [WIDTH-1:0] grayReg;
  logic             wrapReg;
  logic             atMaxReg;
  logic             atMinReg;

  // Load beats count, count beats hold.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; otherwise synthesis infers a latch.
    stepOp = OpHold;
    if (load) begin
      stepOp = OpLoad;
    end else if (en) begin
      stepOp = up ? OpInc : OpDec;
    end
  end

  always_comb begin
    nextCnt  = cnt;
    nextWrap = 1'b0;
    unique case (stepOp)
      OpLoad: nextCnt = load_bin;
      OpInc: begin
        if (cnt == MaxCount) begin
          nextWrap = 1'b1;
          nextCnt  = SATURATE ? cnt : MinCount;
        end else begin
          nextCnt = cnt + One;
        end
      end
      OpDec: begin
        if (cnt == MinCount) begin
          nextWrap = 1'b1;
          nextCnt  = SATURATE ? cnt : MaxCount;
        end else begin
          nextCnt = cnt - One;
        end
      end
      default: begin
        nextCnt  = cnt;
        nextWrap = 1'b0;
      end
    endcase
  end

  // Gray is computed on next-state so it updates on the same edge as cnt.
  bin_to_gray_n #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .binIn  (nextCnt),
    .grayOut(nextGray)
  );

  // NOTE: every register here has a defined reset value because downstream
  // compare logic reads the flags immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= ResetCnt;
      grayReg  <= ResetGray;
      wrapReg  <= 1'b0;
      atMaxReg <= 1'b0;
      atMinReg <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      cnt      <= nextCnt;
      grayReg  <= nextGray;
      wrapReg  <= nextWrap;
      atMaxReg <= (nextCnt == MaxCount);
      atMinReg <= (nextCnt == MinCount);
    end
  end

  assign bin    = cnt;
  assign gray   = grayReg;
  assign wrap   = wrapReg;
  assign at_max = atMaxReg;
  assign at_min = atMinReg;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: a wrapping and a saturating instance
// share stimulus; a scoreboard queue per instance holds the expected outputs.
module tb_gray_updown_counter;

  typedef struct {
    logic [2:0] bin;
    logic [2:0] gray;
    logic       wrap;
    logic       atMax;
    logic       atMin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_bin = 3'd0;

  logic [2:0] gray0, bin0, gray1, bin1;
  logic       wrap0, atMax0, atMin0, wrap1, atMax1, atMin1;

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [2:0] modelCnt[2];

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(3), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(gray0), .bin(bin0), .wrap(wrap0), .at_max(atMax0), .at_min(atMin0)
  );

  gray_updown_counter #(.WIDTH(3), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(gray1), .bin(bin1), .wrap(wrap1), .at_max(atMax1), .at_min(atMin1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t makeExp(input logic [2:0] c, input logic w);
    exp_t e;
    e.bin   = c;
    e.gray  = {c[2], c[2] ^ c[1], c[1] ^ c[0]};
    e.wrap  = w;
    e.atMax = (c == 3'd7);
    e.atMin = (c == 3'd0);
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] c, input bit sat, input logic e,
                                 input logic u, input logic l, input logic [2:0] lb);
    if (l) return makeExp(lb, 1'b0);
    if (!e) return makeExp(c, 1'b0);
    if (u) begin
      if (c == 3'd7) return makeExp(sat ? 3'd7 : 3'd0, 1'b1);
      return makeExp(c + 3'd1, 1'b0);
    end
    if (c == 3'd0) return makeExp(sat ? 3'd0 : 3'd7, 1'b1);
    return makeExp(c - 3'd1, 1'b0);
  endfunction

  task automatic compareOutputs(input string tag);
    exp_t e0, e1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check({tag, " wrap0.bin"},   32'(bin0),   32'(e0.bin));
    check({tag, " wrap0.gray"},  32'(gray0),  32'(e0.gray));
    check({tag, " wrap0.wrap"},  32'(wrap0),  32'(e0.wrap));
    check({tag, " wrap0.atMax"}, 32'(atMax0), 32'(e0.atMax));
    check({tag, " wrap0.atMin"}, 32'(atMin0), 32'(e0.atMin));
    check({tag, " sat1.bin"},    32'(bin1),   32'(e1.bin));
    check({tag, " sat1.gray"},   32'(gray1),  32'(e1.gray));
    check({tag, " sat1.wrap"},   32'(wrap1),  32'(e1.wrap));
    check({tag, " sat1.atMax"},  32'(atMax1), 32'(e1.atMax));
    check({tag, " sat1.atMin"},  32'(atMin1), 32'(e1.atMin));
  endtask

  task automatic step(input logic e, input logic u, input logic l, input logic [2:0] lb,
                      input string tag);
    exp_t x;
    logic [2:0] prevGray0;
    @(negedge clk);
    en = e; up = u; load = l; load_bin = lb;
    x = model(modelCnt[0], 1'b0, e, u, l, lb); modelCnt[0] = x.bin; q0.push_back(x);
    x = model(modelCnt[1], 1'b1, e, u, l, lb); modelCnt[1] = x.bin; q1.push_back(x);
    prevGray0 = gray0;
    @(posedge clk);
    #1;
    if (e && !l) check({tag, " unit-distance"}, 32'($countones(gray0 ^ prevGray0)), 32'd1);
    compareOutputs(tag);
  endtask

  task automatic pushReset();
    modelCnt[0] = 3'd0;
    modelCnt[1] = 3'd0;
    q0.push_back(makeExp(3'd0, 1'b0));
    q1.push_back(makeExp(3'd0, 1'b0));
  endtask

  initial begin
    // Power-on reset.
    pushReset();
    repeat (2) @(posedge clk);
    #1;
    compareOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count up across the wrap: dut0 wraps 7->0, dut1 saturates at 7.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 3'd0, $sformatf("up%0d", i));

    // Load 5 then count down six times across zero.
    step(1'b0, 1'b0, 1'b1, 3'd5, "load5");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 3'd0, $sformatf("down%0d", i));

    // Sustained pressure at the top: dut1 holds at 7 with wrap on every edge.
    step(1'b0, 1'b0, 1'b1, 3'd7, "load7");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'd0, $sformatf("sat%0d", i));

    // Direction toggle across zero gives back-to-back wrap pulses.
    step(1'b0, 1'b0, 1'b1, 3'd0, "load0");
    step(1'b1, 1'b0, 1'b0, 3'd0, "toggleDown");
    step(1'b1, 1'b1, 1'b0, 3'd0, "toggleUp");

    // Load wins over enable, then counting resumes from the loaded value.
    step(1'b0, 1'b0, 1'b1, 3'd2, "load2");
    step(1'b1, 1'b1, 1'b1, 3'd6, "loadBeatsEn");
    step(1'b1, 1'b1, 1'b0, 3'd0, "resume");
    step(1'b0, 1'b0, 1'b1, 3'd7, "loadSame");
    step(1'b0, 1'b0, 1'b1, 3'd7, "loadSameAgain");

    // Asynchronous reset in the middle of a cycle while bin=5.
    step(1'b0, 1'b0, 1'b1, 3'd5, "load5b");
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    #2;
    rst_n = 1'b0;
    pushReset();
    #1;
    compareOutputs("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3'd0, "postReset");

    // Enable gating from zero: 1,1,1,2 with no wrap.
    step(1'b0, 1'b0, 1'b1, 3'd0, "load0b");
    step(1'b1, 1'b1, 1'b0, 3'd0, "gate1");
    step(1'b0, 1'b1, 1'b0, 3'd0, "gate0a");
    step(1'b0, 1'b1, 1'b0, 3'd0, "gate0b");
    step(1'b1, 1'b1, 1'b0, 3'd0, "gate1b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
